// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
// Shares one single-ported memory between the fetch read port (pc) and the
// execute-stage load/store port (ldst). Requests are level-held and use an
// Avalon-style wait handshake. The command path is combinational, so a granted
// request reaches the memory in the same cycle. Reads are tracked in a
// READ_LAT-deep tag pipe so that each returned word goes back to the requester
// that issued it.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-low reset
//   i_pc_rd/i_pc_addr      fetch read request; o_pc_wait stalls it
//   o_pc_rddata(_valid)    fetch read return (one-cycle valid pulse)
//   i_ldst_rd/_wr/_addr/_wrdata  load/store request; o_ldst_wait stalls it
//   o_ldst_rddata(_valid)  load read return (one-cycle valid pulse)
//   o_mem_rd/_wr/_addr/_wrdata, i_mem_waitrequest, i_mem_rddata  memory side
//   o_protocol_err         sticky flag: load and store requested together
module cpu_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int READ_LAT   = 1,
  parameter int STREAK_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_pc_rd,
  input  logic [AW-1:0] i_pc_addr,
  output logic          o_pc_wait,
  output logic [DW-1:0] o_pc_rddata,
  output logic          o_pc_rddata_valid,
  input  logic          i_ldst_rd,
  input  logic          i_ldst_wr,
  input  logic [AW-1:0] i_ldst_addr,
  input  logic [DW-1:0] i_ldst_wrdata,
  output logic          o_ldst_wait,
  output logic [DW-1:0] o_ldst_rddata,
  output logic          o_ldst_rddata_valid,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wrdata,
  input  logic          i_mem_waitrequest,
  input  logic [DW-1:0] i_mem_rddata,
  output logic          o_protocol_err
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

  // state: lock holds a stalled grant; tag pipe bit own = 1 means ldst
  logic                lock_q, lock_d;
  logic                lock_ldst_q, lock_ldst_d;
  logic [SW-1:0]       streak_q, streak_d;
  logic [READ_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [READ_LAT-1:0] tag_own_q, tag_own_d;
  logic                perr_q, perr_d;

  logic          ldst_req_s, gnt_pc_s, gnt_ldst_s;
  logic          mem_rd_s, mem_wr_s, accept_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wrdata_s;

  assign ldst_req_s = i_ldst_rd | i_ldst_wr;

  // Grant selection: a stalled command keeps its grant; otherwise ldst wins
  // unless fetch has been passed over STREAK_MAX times in a row.
  always_comb begin
    gnt_pc_s   = 1'b0;
    gnt_ldst_s = 1'b0;
    if (lock_q) begin
      if (lock_ldst_q) begin
        gnt_ldst_s = ldst_req_s;
      end else begin
        gnt_pc_s = i_pc_rd;
      end
    end else if (ldst_req_s && i_pc_rd) begin
      if (streak_q == STREAK_TOP) begin
        gnt_pc_s = 1'b1;
      end else begin
        gnt_ldst_s = 1'b1;
      end
    end else begin
      gnt_pc_s   = i_pc_rd;
      gnt_ldst_s = ldst_req_s;
    end
  end

  // Command mux; a simultaneous load+store issues the store.
  always_comb begin
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    mem_addr_s   = {AW{1'b0}};
    mem_wrdata_s = {DW{1'b0}};
    if (gnt_pc_s) begin
      mem_rd_s   = 1'b1;
      mem_addr_s = i_pc_addr;
    end else if (gnt_ldst_s) begin
      mem_wr_s     = i_ldst_wr;
      mem_rd_s     = i_ldst_rd & ~i_ldst_wr;
      mem_addr_s   = i_ldst_addr;
      mem_wrdata_s = i_ldst_wrdata;
    end else begin
      mem_rd_s = 1'b0;
    end
  end

  assign accept_s = (mem_rd_s | mem_wr_s) & ~i_mem_waitrequest;

  // Next state for lock, starvation streak, read tag pipe and error flag.
  always_comb begin
    lock_d      = (mem_rd_s | mem_wr_s) & i_mem_waitrequest;
    lock_ldst_d = gnt_ldst_s;
    perr_d      = perr_q | (i_ldst_rd & i_ldst_wr);
    streak_d    = streak_q;
    if (!i_pc_rd) begin
      streak_d = {SW{1'b0}};
    end else if (accept_s && gnt_pc_s) begin
      streak_d = {SW{1'b0}};
    end else if (accept_s && gnt_ldst_s && (streak_q != STREAK_TOP)) begin
      streak_d = streak_q + SW'(1);
    end else begin
      streak_d = streak_q;
    end
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = accept_s & mem_rd_s;
    tag_own_d[0] = gnt_ldst_s;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  // State registers; reset also discards reads still in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      lock_q      <= 1'b0;
      lock_ldst_q <= 1'b0;
      streak_q    <= {SW{1'b0}};
      tag_vld_q   <= {READ_LAT{1'b0}};
      tag_own_q   <= {READ_LAT{1'b0}};
      perr_q      <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lock_ldst_q <= lock_ldst_d;
      streak_q    <= streak_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      perr_q      <= perr_d;
    end
  end

  // The command path is combinational from the request inputs, so it is
  // masked by the reset level to keep every output at 0 during reset.
  always_comb begin
    o_pc_wait           = i_reset & i_pc_rd & ~(gnt_pc_s & accept_s);
    o_ldst_wait         = i_reset & ldst_req_s & ~(gnt_ldst_s & accept_s);
    o_mem_rd            = i_reset & mem_rd_s;
    o_mem_wr            = i_reset & mem_wr_s;
    o_mem_addr          = i_reset ? mem_addr_s : {AW{1'b0}};
    o_mem_wrdata        = i_reset ? mem_wrdata_s : {DW{1'b0}};
    o_pc_rddata_valid   = tag_vld_q[READ_LAT-1] & ~tag_own_q[READ_LAT-1];
    o_ldst_rddata_valid = tag_vld_q[READ_LAT-1] & tag_own_q[READ_LAT-1];
    o_pc_rddata         = o_pc_rddata_valid ? i_mem_rddata : {DW{1'b0}};
    o_ldst_rddata       = o_ldst_rddata_valid ? i_mem_rddata : {DW{1'b0}};
    o_protocol_err      = perr_q;
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: one instance with READ_LAT=2 driven by a vector
// table and checked through a read-return scoreboard, plus a READ_LAT=3
// instance sharing the same request inputs, used for the reset-with-reads-
// in-flight sequence.
module tb_cpu_mem_arbiter;
  localparam int LAT  = 2;
  localparam int LAT3 = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pc_rd, ldst_rd, ldst_wr, wreq;
  logic [15:0] pc_addr, ldst_addr, wrdata;
  logic        pc_wait, pc_rv, ld_wait, ld_rv, mem_rd, mem_wr, perr;
  logic [15:0] pc_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        pc_wait3, pc_rv3, ld_wait3, ld_rv3, mem_rd3, mem_wr3, perr3;
  logic [15:0] pc_rdata3, ld_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  cpu_mem_arbiter #(.AW(16), .DW(16), .READ_LAT(LAT), .STREAK_MAX(SMAX)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_pc_rd(pc_rd), .i_pc_addr(pc_addr),
    .o_pc_wait(pc_wait), .o_pc_rddata(pc_rdata), .o_pc_rddata_valid(pc_rv),
    .i_ldst_rd(ldst_rd), .i_ldst_wr(ldst_wr), .i_ldst_addr(ldst_addr),
    .i_ldst_wrdata(wrdata), .o_ldst_wait(ld_wait), .o_ldst_rddata(ld_rdata),
    .o_ldst_rddata_valid(ld_rv), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
    .o_mem_addr(mem_addr), .o_mem_wrdata(mem_wdata),
    .i_mem_waitrequest(wreq), .i_mem_rddata(mem_rdata), .o_protocol_err(perr)
  );

  cpu_mem_arbiter #(.AW(16), .DW(16), .READ_LAT(LAT3), .STREAK_MAX(SMAX)) dut3 (
    .i_clk(clk), .i_reset(rst_n), .i_pc_rd(pc_rd), .i_pc_addr(pc_addr),
    .o_pc_wait(pc_wait3), .o_pc_rddata(pc_rdata3), .o_pc_rddata_valid(pc_rv3),
    .i_ldst_rd(ldst_rd), .i_ldst_wr(ldst_wr), .i_ldst_addr(ldst_addr),
    .i_ldst_wrdata(wrdata), .o_ldst_wait(ld_wait3), .o_ldst_rddata(ld_rdata3),
    .o_ldst_rddata_valid(ld_rv3), .o_mem_rd(mem_rd3), .o_mem_wr(mem_wr3),
    .o_mem_addr(mem_addr3), .o_mem_wrdata(mem_wdata3),
    .i_mem_waitrequest(wreq), .i_mem_rddata(mem_rdata3), .o_protocol_err(perr3)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hC35A;
  endfunction

  // Fixed-latency memory read pipes, one per instance.
  logic [15:0] pipe2 [LAT];
  logic [15:0] pipe3 [LAT3];
  always @(posedge clk) begin
    pipe2[0] <= (mem_rd && !wreq) ? mem_f(mem_addr) : 16'h0000;
    for (int i = 1; i < LAT; i++) pipe2[i] <= pipe2[i-1];
    pipe3[0] <= (mem_rd3 && !wreq) ? mem_f(mem_addr3) : 16'h0000;
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign mem_rdata  = pipe2[LAT-1];
  assign mem_rdata3 = pipe3[LAT3-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [15:0] data; int due; } exp_t;
  exp_t pc_q[$];
  exp_t ld_q[$];

  // Scoreboard: every valid pulse must match the oldest expected return.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (pc_rv) begin
        if (pc_q.size() == 0) chk("pc_spurious_q", 32'(pc_q.size()), 32'd1);
        else begin
          e = pc_q.pop_front();
          chk("pc_data", 32'(pc_rdata), 32'(e.data));
          chk("pc_due", 32'(cyc), 32'(e.due));
        end
      end
      if (ld_rv) begin
        if (ld_q.size() == 0) chk("ld_spurious_q", 32'(ld_q.size()), 32'd1);
        else begin
          e = ld_q.pop_front();
          chk("ld_data", 32'(ld_rdata), 32'(e.data));
          chk("ld_due", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // Pulse log for the READ_LAT=3 instance.
  int          p3_cnt = 0;
  int          p3_cyc = 0;
  logic [15:0] p3_data = 16'h0000;
  logic        p3_pc = 1'b0;
  always @(negedge clk) begin
    if (pc_rv3 || ld_rv3) begin
      p3_cnt  <= p3_cnt + 1;
      p3_cyc  <= cyc;
      p3_data <= pc_rv3 ? pc_rdata3 : ld_rdata3;
      p3_pc   <= pc_rv3;
    end
  end

  typedef struct {
    bit pc; logic [15:0] pa; bit lr; bit lw; logic [15:0] la; logic [15:0] wd; bit wq;
    bit epw; bit elw; bit erd; bit ewr; logic [15:0] ea; bit eperr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit pc, input logic [15:0] pa, input bit lr, input bit lw,
                              input logic [15:0] la, input logic [15:0] wd, input bit wq,
                              input bit epw, input bit elw, input bit erd, input bit ewr,
                              input logic [15:0] ea, input bit eperr);
    vec_t v;
    v.pc = pc; v.pa = pa; v.lr = lr; v.lw = lw; v.la = la; v.wd = wd; v.wq = wq;
    v.epw = epw; v.elw = elw; v.erd = erd; v.ewr = ewr; v.ea = ea; v.eperr = eperr;
    return v;
  endfunction

  function automatic vec_t idle(input bit eperr);
    return mk(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0, eperr);
  endfunction

  // Drive one cycle (entered just after a rising edge), register any expected
  // read return, compare the combinational outputs at the falling edge.
  task automatic apply(input vec_t v);
    exp_t e;
    pc_rd = v.pc; pc_addr = v.pa; ldst_rd = v.lr; ldst_wr = v.lw;
    ldst_addr = v.la; wrdata = v.wd; wreq = v.wq;
    if (v.erd && !v.wq) begin
      e.due = cyc + LAT;
      if (v.pc && !v.epw) begin e.data = mem_f(v.pa); pc_q.push_back(e); end
      else begin e.data = mem_f(v.la); ld_q.push_back(e); end
    end
    @(negedge clk);
    chk("ctl{pcw,lw,rd,wr,err}", {27'd0, pc_wait, ld_wait, mem_rd, mem_wr, perr},
        {27'd0, v.epw, v.elw, v.erd, v.ewr, v.eperr});
    chk("mem_addr", 32'(mem_addr), 32'(v.ea));
    if (v.ewr) chk("mem_wrdata", 32'(mem_wdata), 32'(v.wd));
    @(posedge clk); #1;
  endtask

  function automatic logic any_out();
    return |{pc_wait, pc_rdata, pc_rv, ld_wait, ld_rdata, ld_rv, mem_rd, mem_wr,
             mem_addr, mem_wdata, perr};
  endfunction
  function automatic logic any_out3();
    return |{pc_wait3, pc_rdata3, pc_rv3, ld_wait3, ld_rdata3, ld_rv3, mem_rd3,
             mem_wr3, mem_addr3, mem_wdata3, perr3};
  endfunction

  initial begin
    int nl;
    int base3;
    int d;
    bit f;
    logic [15:0] pa;

    // Reset state with every request active.
    rst_n = 1'b0; pc_rd = 1'b1; pc_addr = 16'h1234; ldst_rd = 1'b1; ldst_wr = 1'b1;
    ldst_addr = 16'h5678; wrdata = 16'h9ABC; wreq = 1'b0;
    @(negedge clk);
    chk("reset_outs", 32'(any_out()), 32'd0);
    chk("reset_outs3", 32'(any_out3()), 32'd0);
    @(posedge clk); #1;
    pc_rd = 1'b0; ldst_rd = 1'b0; ldst_wr = 1'b0; rst_n = 1'b1;

    // Fetch-only stream.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 16'(i), 0, 0, 16'h0, 16'h0, 0, 0, 0, 1, 0, 16'(i), 0));
    tbl.push_back(idle(0));
    // Simultaneous fetch and load: load first.
    tbl.push_back(mk(1, 16'h0010, 1, 0, 16'h0100, 16'h0, 0, 1, 0, 1, 0, 16'h0100, 0));
    tbl.push_back(mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 1, 0, 16'h0010, 0));
    // Starvation guard: ldst x4, pc, ldst x4, pc.
    nl = 0;
    for (int i = 0; i < 10; i++) begin
      f  = (i == 4) || (i == 9);
      pa = (i <= 4) ? 16'h0040 : 16'h0041;
      tbl.push_back(mk(1, pa, 1, 0, 16'(16'h0200 + nl), 16'h0, 0, !f, f, 1, 0,
                       f ? pa : 16'(16'h0200 + nl), 0));
      if (!f) nl++;
    end
    tbl.push_back(idle(0));
    // Stalled fetch keeps the grant while a store arrives.
    tbl.push_back(mk(1, 16'h0080, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 0, 16'h0080, 0));
    tbl.push_back(mk(1, 16'h0080, 0, 1, 16'h0300, 16'h1111, 1, 1, 1, 1, 0, 16'h0080, 0));
    tbl.push_back(mk(1, 16'h0080, 0, 1, 16'h0300, 16'h1111, 1, 1, 1, 1, 0, 16'h0080, 0));
    tbl.push_back(mk(1, 16'h0080, 0, 1, 16'h0300, 16'h1111, 0, 0, 1, 1, 0, 16'h0080, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h0300, 16'h1111, 0, 0, 0, 0, 1, 16'h0300, 0));
    // Plain store, then load+store together.
    tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h0020, 16'hBEEF, 0, 0, 0, 0, 1, 16'h0020, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 16'h0022, 16'h1234, 0, 0, 0, 0, 1, 16'h0022, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(1));
    tbl.push_back(idle(1));

    foreach (tbl[i]) apply(tbl[i]);
    chk("pc_q_drained", 32'(pc_q.size()), 32'd0);
    chk("ld_q_drained", 32'(ld_q.size()), 32'd0);

    // Reset with two fetches in flight in the READ_LAT=3 instance.
    pc_rd = 1'b1; pc_addr = 16'h0005; wreq = 1'b0;
    @(posedge clk); #1;
    pc_addr = 16'h0006;
    @(posedge clk); #1;
    base3 = p3_cnt;
    rst_n = 1'b0;
    #1;
    chk("inrst_outs", 32'(any_out()), 32'd0);
    chk("inrst_outs3", 32'(any_out3()), 32'd0);
    @(posedge clk); #1;
    pc_rd = 1'b0; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_discard3", 32'(p3_cnt - base3), 32'd0);

    // First fetch after reset returns normally on both instances.
    d = cyc;
    apply(mk(1, 16'h0077, 0, 0, 16'h0, 16'h0, 0, 0, 0, 1, 0, 16'h0077, 0));
    repeat (4) apply(idle(0));
    chk("post_rst_cnt3", 32'(p3_cnt - base3), 32'd1);
    chk("post_rst_cyc3", 32'(p3_cyc), 32'(d + LAT3));
    chk("post_rst_data3", 32'(p3_data), 32'(mem_f(16'h0077)));
    chk("post_rst_pc3", 32'(p3_pc), 32'd1);
    chk("pc_q_end", 32'(pc_q.size()), 32'd0);
    chk("ld_q_end", 32'(ld_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch stage (PC read port) and the execute-stage load/store port.
- Sits between the pipeline controller/datapath and memory.
- Accepts level-held requests with an Avalon-style wait handshake and issues one memory command per cycle.
- Tracks in-flight reads for a fixed-latency memory and returns read data to the requester that issued it.
- Load/store normally has priority; a streak counter prevents fetch starvation.

Parameters:
AW, 16, address width
DW, 16, data width
READ_LAT, 1, cycles from accepted read command to i_mem_rddata valid; must be >= 1
STREAK_MAX, 4, max consecutive accepted ldst commands while fetch is pending before fetch is forced

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_pc_rd  in  1  fetch read request, held until accepted
i_pc_addr  in  AW  fetch address
o_pc_wait  out  1  fetch request not accepted this cycle
o_pc_rddata  out  DW  fetch read data
o_pc_rddata_valid  out  1  one-cycle pulse, o_pc_rddata valid
i_ldst_rd  in  1  load request
i_ldst_wr  in  1  store request
i_ldst_addr  in  AW  load/store address
i_ldst_wrdata  in  DW  store data
o_ldst_wait  out  1  ldst request not accepted this cycle
o_ldst_rddata  out  DW  load data
o_ldst_rddata_valid  out  1  one-cycle pulse, o_ldst_rddata valid
o_mem_rd  out  1  memory read command
o_mem_wr  out  1  memory write command
o_mem_addr  out  AW  memory address
o_mem_wrdata  out  DW  memory write data
i_mem_waitrequest  in  1  memory stalls current command
i_mem_rddata  in  DW  memory read data, valid READ_LAT cycles after acceptance
o_protocol_err  out  1  sticky: i_ldst_rd and i_ldst_wr seen together

Behaviour:
- Reset:
  - While i_reset = 0, all outputs are 0.
  - Lock, streak counter, tag pipe and o_protocol_err are cleared.
  - Reads in flight at reset are discarded: no valid pulse follows.
- Handshake:
  - Requesters hold the request and operands stable while their o_*_wait is high.
  - A command is accepted when o_mem_rd or o_mem_wr is high and i_mem_waitrequest = 0.
  - o_x_wait = req_x AND NOT (granted_x AND accepted). The port is combinational and zero-latency to the memory.
- Arbitration (when unlocked):
  - If only one requester is active, grant it.
  - If both are active, grant ldst, unless streak == STREAK_MAX; then grant fetch.
- Lock:
  - If the granted command sees i_mem_waitrequest = 1, the lock register holds that grant until it is accepted.
  - No switching or re-arbitration mid-command.
  - A newly arriving higher-priority request waits.
- Streak counter (0..STREAK_MAX):
  - +1 on each accepted ldst command while i_pc_rd = 1; saturates.
  - Cleared on accepted fetch, or in any cycle with i_pc_rd = 0.
- Command mux:
  - Fetch grant: o_mem_rd = 1, o_mem_addr = i_pc_addr.
  - ldst grant: o_mem_wr = i_ldst_wr; o_mem_rd = i_ldst_rd AND NOT i_ldst_wr; o_mem_addr = i_ldst_addr; o_mem_wrdata = i_ldst_wrdata.
  - rd+wr together: the write is issued and o_protocol_err sets (sticky until reset).
- Read return:
  - READ_LAT-deep tag shift register of {valid, owner}.
  - An accepted read pushes {1, owner}; an accepted write or an idle cycle pushes {0, x}.
  - At the tail, i_mem_rddata is routed to o_pc_rddata or o_ldst_rddata, and the matching valid pulses for exactly one cycle.
  - Order is preserved; throughput is one read per cycle with no waitrequest.
- No buffering of requests. Maximum one accepted command per cycle.

Test Plan:
1. READ_LAT=2, fetch only, pc_rd held 5 cycles with addresses 0x0000..0x0004, waitrequest=0 -> o_mem_rd each cycle; o_pc_rddata_valid pulses 2 cycles after each accept with data = mem[addr]; o_pc_wait = 0 throughout.
2. pc_rd@0x0010 and ldst_rd@0x0100 in the same cycle -> ldst accepted first with o_pc_wait = 1; fetch accepted the next cycle; valids arrive ldst then pc, each with correct data.
3. STREAK_MAX=4, ldst_rd and pc_rd both held 10 cycles -> accepted order: ldst x4, pc, ldst x4, pc; streak returns to 0 after each fetch.
4. Fetch granted with waitrequest=1 for 3 cycles, ldst_wr rises in cycle 1 -> o_mem_addr stays at pc_addr and the grant stays on fetch; ldst is accepted the cycle after fetch acceptance.
5. ldst_wr of 0xBEEF to 0x0020 -> o_mem_wr = 1 with that address and data, no valid pulse. ldst_rd and ldst_wr together -> write issued, o_protocol_err = 1 and stays 1.
6. i_reset low for 1 cycle with 2 reads in flight (READ_LAT=3) -> no valid pulses afterwards; all outputs 0 during reset; the first post-reset fetch returns correctly.
